// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//
// Receive front end for the UART: oversamples the asynchronous rx line,
// frames 8N1-style characters (DATA_WIDTH data bits, LSB first, one stop bit,
// no parity) and hands each good character to the receive FIFO as a
// single-cycle write strobe plus data.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   rx         raw serial line, idle high, asynchronous to clk
//   fifo_full  full flag from the downstream FIFO
//   clr_err    synchronous clear for the sticky error flags
//   rx_data    last accepted character (held between strobes)
//   rx_valid   one-cycle write strobe to the FIFO
//   frame_err  sticky: stop bit sampled low
//   overrun    sticky: good character dropped because the FIFO was full
//   busy       high while a character (or a break) is in progress
//
// State table:
//   state    | meaning
//   S_IDLE   | line idle, waiting for a low level on the synchronized rx
//   S_START  | timing to the middle of the start bit to confirm it
//   S_DATA   | sampling data bits at bit centres, LSB first
//   S_STOP   | sampling the stop bit, deciding strobe / overrun / framing error
//   S_BREAK  | stop bit was low; wait for the line to return high

module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  fifo_full,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                state_q,     state_d;
    logic                  sync1_q,     sync1_d;
    logic                  rxs_q,       rxs_d;
    logic [CW-1:0]         cnt_q,       cnt_d;
    logic [IW-1:0]         bit_idx_q,   bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic [DATA_WIDTH-1:0] rx_data_q,   rx_data_d;
    logic                  rx_valid_q,  rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q,   overrun_d;
    logic                  busy_q,      busy_d;

    logic                  frame_set;
    logic                  overrun_set;

    always_comb begin
        state_d     = state_q;
        sync1_d     = rx;
        rxs_d       = sync1_q;
        cnt_d       = cnt_q + CW'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_set   = 1'b0;
        overrun_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        // Too short to be a start bit: drop it silently.
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d             = '0;
                    shift_d[bit_idx_q] = rxs_q;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        state_d = S_IDLE;
                        if (!fifo_full) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_set = 1'b1;
                        end
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A line held low must go high before the next start edge counts.
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // A new error event in the same cycle as clr_err leaves the flag set.
        frame_err_d = frame_set   | (frame_err_q & ~clr_err);
        overrun_d   = overrun_set | (overrun_q   & ~clr_err);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rxs_q       <= rxs_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Testbench for uart_rx_deserializer: directed frame table, hand-written
// corner sequences and randomized frames against a frame-level model.

module tb_uart_rx_deserializer;

    localparam int N   = 16;
    localparam int H   = N / 2;
    localparam int DW  = 8;
    // rx is driven on a negedge, so the first capturing posedge is one cycle
    // later; then 2 sync cycles, half a bit to the start centre, 9 bit times
    // to the stop centre; the strobe is visible right after that edge.
    localparam int LAT = 1 + 2 + H + (DW + 1) * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          fifo_full;
    logic          clr_err;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_deserializer #(.CLKS_PER_BIT(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .fifo_full (fifo_full),
        .clr_err   (clr_err),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Strobe monitor
    logic          prev_valid = 1'b0;
    logic [DW-1:0] got_data[$];
    int            got_cyc[$];

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            check("no_back_to_back_strobe", 32'(prev_valid), 32'd0);
            got_data.push_back(rx_data);
            got_cyc.push_back(cyc);
        end
        prev_valid <= rx_valid;
    end

    int fall_cyc;

    // Drives start, data and stop bits; leaves rx at the stop level.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit);
        rx       = 1'b0;
        fall_cyc = cyc;
        repeat (N) @(negedge clk);
        for (int k = 0; k < DW; k++) begin
            rx = d[k];
            repeat (N) @(negedge clk);
        end
        rx = stop_bit;
        repeat (N) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    typedef struct {
        logic          clr;
        logic [DW-1:0] d;
        logic          stop;
        logic          full;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          exp_ferr;
        logic          exp_ovr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int base;
        int gap;
        logic [DW-1:0] v;
        logic [DW-1:0] d;
        logic          full;
        logic          stop;
        logic [DW-1:0] m_data;
        logic          m_ferr;
        logic          m_ovr;
        logic [DW-1:0] e_data[$];
        int            e_cyc[$];

        vecs[0] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 8'h12, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 8'h78, 1'b1, 1'b0, 1'b1, 8'h78, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};

        rst = 1'b1; rx = 1'b1; fifo_full = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_data",   32'(rx_data),   32'd0);
        check("reset_rx_valid",  32'(rx_valid),  32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overrun",   32'(overrun),   32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Directed frame table
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].clr) pulse_clr();
            fifo_full = vecs[i].full;
            n0 = got_data.size();
            send_frame(vecs[i].d, vecs[i].stop);
            rx = 1'b1;
            repeat (2 * N) @(negedge clk);
            fifo_full = 1'b0;
            check($sformatf("vec%0d_strobes", i), 32'(got_data.size() - n0), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid && got_data.size() > n0)
                check($sformatf("vec%0d_latency", i), 32'(got_cyc[n0] - fall_cyc), 32'(LAT));
            check($sformatf("vec%0d_rx_data", i),   32'(rx_data),   32'(vecs[i].exp_data));
            check($sformatf("vec%0d_frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_overrun", i),   32'(overrun),   32'(vecs[i].exp_ovr));
            check($sformatf("vec%0d_busy", i),      32'(busy),      32'd0);
        end

        // Back-to-back characters with no idle gap
        n0 = got_data.size();
        send_frame(8'h00, 1'b1);
        base = fall_cyc;
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        rx = 1'b1;
        repeat (2 * N) @(negedge clk);
        check("b2b_strobes", 32'(got_data.size() - n0), 32'd3);
        if (got_data.size() >= n0 + 3) begin
            check("b2b_data0", 32'(got_data[n0]),     32'h00);
            check("b2b_data1", 32'(got_data[n0 + 1]), 32'hFF);
            check("b2b_data2", 32'(got_data[n0 + 2]), 32'h3C);
            check("b2b_lat0",  32'(got_cyc[n0] - base), 32'(LAT));
            check("b2b_gap01", 32'(got_cyc[n0 + 1] - got_cyc[n0]),     32'(10 * N));
            check("b2b_gap12", 32'(got_cyc[n0 + 2] - got_cyc[n0 + 1]), 32'(10 * N));
        end

        // Bad stop bit, clr_err coinciding with the error (set wins), then break
        n0 = got_data.size();
        fork
            send_frame(8'h55, 1'b0);
            begin
                repeat (LAT - 1) @(negedge clk);
                clr_err = 1'b1;
                @(negedge clk);
                clr_err = 1'b0;
            end
        join
        check("brk_frame_err_set_wins", 32'(frame_err), 32'd1);
        repeat (50 * N) @(negedge clk);
        check("brk_held_busy",   32'(busy),      32'd1);
        check("brk_held_ferr",   32'(frame_err), 32'd1);
        check("brk_held_strobe", 32'(got_data.size() - n0), 32'd0);
        rx = 1'b1;
        repeat (2 * N) @(negedge clk);
        check("brk_release_busy", 32'(busy), 32'd0);
        send_frame(8'h12, 1'b1);
        rx = 1'b1;
        repeat (2 * N) @(negedge clk);
        check("brk_next_strobes", 32'(got_data.size() - n0), 32'd1);
        check("brk_next_data",    32'(rx_data), 32'h12);
        pulse_clr();
        @(negedge clk);
        check("brk_clr_ferr", 32'(frame_err), 32'd0);

        // Short low glitch
        n0 = got_data.size();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        check("glitch_busy_during", 32'(busy), 32'd1);
        repeat (2 * N) @(negedge clk);
        check("glitch_busy_after", 32'(busy),      32'd0);
        check("glitch_strobes",    32'(got_data.size() - n0), 32'd0);
        check("glitch_ferr",       32'(frame_err), 32'd0);
        check("glitch_ovr",        32'(overrun),   32'd0);

        // Reset during data bit 3
        v = 8'hC3;
        n0 = got_data.size();
        rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            rx = v[k];
            repeat (N) @(negedge clk);
        end
        rx = v[3];
        repeat (H) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async_rx_data",  32'(rx_data),   32'd0);
        check("rst_async_rx_valid", 32'(rx_valid),  32'd0);
        check("rst_async_ferr",     32'(frame_err), 32'd0);
        check("rst_async_ovr",      32'(overrun),   32'd0);
        check("rst_async_busy",     32'(busy),      32'd0);
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * N) @(negedge clk);
        check("rst_no_strobe", 32'(got_data.size() - n0), 32'd0);
        send_frame(8'hC3, 1'b1);
        rx = 1'b1;
        repeat (2 * N) @(negedge clk);
        check("rst_next_strobes", 32'(got_data.size() - n0), 32'd1);
        check("rst_next_data",    32'(rx_data), 32'hC3);
        if (got_data.size() > n0)
            check("rst_next_latency", 32'(got_cyc[n0] - fall_cyc), 32'(LAT));

        // Randomized frames against a frame-level model
        m_data = 8'hC3; m_ferr = 1'b0; m_ovr = 1'b0;
        base = got_data.size();
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                pulse_clr();
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
            d    = 8'($urandom);
            full = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 7) != 0);
            fifo_full = full;
            send_frame(d, stop);
            rx = 1'b1;
            if (stop && !full) begin
                e_data.push_back(d);
                e_cyc.push_back(fall_cyc + LAT);
                m_data = d;
            end else if (stop) begin
                m_ovr = 1'b1;
            end else begin
                m_ferr = 1'b1;
            end
            check($sformatf("rand%0d_rx_data", f),   32'(rx_data),   32'(m_data));
            check($sformatf("rand%0d_frame_err", f), 32'(frame_err), 32'(m_ferr));
            check($sformatf("rand%0d_overrun", f),   32'(overrun),   32'(m_ovr));
            gap = stop ? $urandom_range(0, 3) : N + $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end
        fifo_full = 1'b0;
        repeat (2 * N) @(negedge clk);
        check("rand_strobe_count", 32'(got_data.size() - base), 32'(e_data.size()));
        for (int i = 0; i < e_data.size(); i++) begin
            if (base + i < got_data.size()) begin
                check($sformatf("rand_strobe%0d_data", i), 32'(got_data[base + i]), 32'(e_data[i]));
                check($sformatf("rand_strobe%0d_cycle", i), 32'(got_cyc[base + i]), 32'(e_cyc[i]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
